// File: rtl/key_pkg.sv
// Shared constants, event kinds and the clog2 helper for the key stack design.
package key_pkg;

    localparam int DEF_NUM_KEYS = 24;
    localparam int DEF_DEPTH    = 8;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2
    } evt_kind_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_stack_if.sv
// Key inputs and all status/event outputs of the key stack, bundled for port lists.
interface key_stack_if
    import key_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int DEPTH    = DEF_DEPTH
);
    localparam int KEY_W = clog2(NUM_KEYS);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [NUM_KEYS-1:0] keys;
    logic [KEY_W-1:0]    key;
    logic                valid;
    logic                press;
    logic [NUM_KEYS-1:0] display;
    logic                note_on;
    logic                note_off;
    logic [KEY_W-1:0]    evt_key;
    logic [CNT_W-1:0]    count;

    modport master (
        output keys,
        input  key, valid, press, display, note_on, note_off, evt_key, count
    );

    modport slave (
        input  keys,
        output key, valid, press, display, note_on, note_off, evt_key, count
    );

endinterface

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: reports whether any bit is set and where the first one is.
module prio_enc
    import key_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_stack.sv
// Last-note-priority held-key stack: one press or release event processed per cycle.
module key_stack
    import key_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input logic       clk,
    input logic       rst,
    key_stack_if.slave bus
);

    localparam int KEY_W = clog2(NUM_KEYS);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [NUM_KEYS-1:0] tracked, tracked_n;
    logic [KEY_W-1:0]    stack      [DEPTH];
    logic [KEY_W-1:0]    stack_n    [DEPTH];
    logic [KEY_W-1:0]    stack_down [DEPTH];
    logic [KEY_W-1:0]    stack_up   [DEPTH];
    logic [CNT_W-1:0]    count, count_n;
    logic                note_on, note_off;
    logic [KEY_W-1:0]    evt_key;

    logic                rel_found, prs_found;
    logic [KEY_W-1:0]    rel_idx, prs_idx;
    evt_kind_e           evt_kind;
    logic [KEY_W-1:0]    evt_idx;
    logic                hit;

    prio_enc #(.WIDTH(NUM_KEYS)) rel_enc (
        .bits  (tracked & ~bus.keys),
        .found (rel_found),
        .index (rel_idx)
    );

    prio_enc #(.WIDTH(NUM_KEYS)) prs_enc (
        .bits  (bus.keys & ~tracked),
        .found (prs_found),
        .index (prs_idx)
    );

    // Releases win so a stale key never lingers on top while new presses queue.
    always_comb begin
        evt_kind = EVT_NONE;
        evt_idx  = '0;
        if (rel_found) begin
            evt_kind = EVT_RELEASE;
            evt_idx  = rel_idx;
        end else if (prs_found) begin
            evt_kind = EVT_PRESS;
            evt_idx  = prs_idx;
        end
    end

    always_comb begin
        stack_down[0] = evt_idx;
        for (int j = 1; j < DEPTH; j++) stack_down[j] = stack[j-1];
        for (int j = 0; j < DEPTH - 1; j++) stack_up[j] = stack[j+1];
        stack_up[DEPTH-1] = '0;
    end

    // A released key missing from the stack was pushed off the bottom earlier.
    always_comb begin
        tracked_n = tracked;
        stack_n   = stack;
        count_n   = count;
        hit       = 1'b0;
        case (evt_kind)
            EVT_PRESS: begin
                tracked_n[evt_idx] = 1'b1;
                stack_n            = stack_down;
                if (count != CNT_W'(DEPTH)) count_n = count + CNT_W'(1);
            end
            EVT_RELEASE: begin
                tracked_n[evt_idx] = 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (CNT_W'(j) < count && stack[j] == evt_idx) hit = 1'b1;
                    if (hit) stack_n[j] = stack_up[j];
                end
                if (hit) count_n = count - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tracked  <= '0;
            for (int j = 0; j < DEPTH; j++) stack[j] <= '0;
            count    <= '0;
            note_on  <= 1'b0;
            note_off <= 1'b0;
            evt_key  <= '0;
        end else begin
            tracked  <= tracked_n;
            stack    <= stack_n;
            count    <= count_n;
            note_on  <= (evt_kind == EVT_PRESS);
            note_off <= (evt_kind == EVT_RELEASE);
            if (evt_kind != EVT_NONE) evt_key <= evt_idx;
        end
    end

    assign bus.valid    = (count != '0);
    assign bus.key      = bus.valid ? stack[0] : '0;
    assign bus.display  = bus.valid ? (NUM_KEYS'(1) << stack[0]) : '0;
    assign bus.press    = |bus.keys;
    assign bus.count    = count;
    assign bus.note_on  = note_on;
    assign bus.note_off = note_off;
    assign bus.evt_key  = evt_key;

endmodule

// File: tb/tb_key_stack.sv
// Directed bench for key_stack: a vector table for the main flow plus hand sequences for corners.
module tb_key_stack;

    localparam int NK = 24;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    key_stack_if #(.NUM_KEYS(NK), .DEPTH(DP)) bus ();

    key_stack #(.NUM_KEYS(NK), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] keys;
        int            ekey;
        bit            evalid;
        bit            eon;
        bit            eoff;
        int            eevt;
        int            ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [NK-1:0] k);
        bus.keys = k;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int ekey, input bit evalid,
                                input bit eon, input bit eoff, input int eevt, input int ecnt);
        logic [NK-1:0] edisp;
        edisp = evalid ? (NK'(1) << ekey) : '0;
        cmp({tag, ".key"},      int'(bus.key),      evalid ? ekey : 0);
        cmp({tag, ".valid"},    int'(bus.valid),    int'(evalid));
        cmp({tag, ".display"},  int'(bus.display),  int'(edisp));
        cmp({tag, ".press"},    int'(bus.press),    int'(|bus.keys));
        cmp({tag, ".note_on"},  int'(bus.note_on),  int'(eon));
        cmp({tag, ".note_off"}, int'(bus.note_off), int'(eoff));
        cmp({tag, ".evt_key"},  int'(bus.evt_key),  eevt);
        cmp({tag, ".count"},    int'(bus.count),    ecnt);
    endtask

    initial begin
        logic [NK-1:0] k;

        // keys, key, valid, on, off, evt_key, count
        vecs.push_back('{24'h000008,  3, 1, 1, 0,  3, 1});
        vecs.push_back('{24'h000000,  0, 0, 0, 1,  3, 0});
        vecs.push_back('{24'h000020,  5, 1, 1, 0,  5, 1});
        vecs.push_back('{24'h000220,  9, 1, 1, 0,  9, 2});
        vecs.push_back('{24'h000020,  5, 1, 0, 1,  9, 1});
        vecs.push_back('{24'h000000,  0, 0, 0, 1,  5, 0});
        vecs.push_back('{24'h100084,  2, 1, 1, 0,  2, 1});
        vecs.push_back('{24'h100084,  7, 1, 1, 0,  7, 2});
        vecs.push_back('{24'h100084, 20, 1, 1, 0, 20, 3});
        vecs.push_back('{24'h100084, 20, 1, 0, 0, 20, 3});
        vecs.push_back('{24'h100004, 20, 1, 0, 1,  7, 2});
        vecs.push_back('{24'h100044,  6, 1, 1, 0,  6, 3});
        vecs.push_back('{24'h100804, 20, 1, 0, 1,  6, 2});
        vecs.push_back('{24'h100804, 11, 1, 1, 0, 11, 3});
        vecs.push_back('{24'h100800, 11, 1, 0, 1,  2, 2});
        vecs.push_back('{24'h000000, 20, 1, 0, 1, 11, 1});
        vecs.push_back('{24'h000000,  0, 0, 0, 1, 20, 0});
        vecs.push_back('{24'h000000,  0, 0, 0, 0, 20, 0});

        rst = 1'b1;
        apply_stimulus('0);
        check_output("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].keys);
            check_output($sformatf("vec%0d", i), vecs[i].ekey, vecs[i].evalid,
                         vecs[i].eon, vecs[i].eoff, vecs[i].eevt, vecs[i].ecnt);
        end

        // Fill past DEPTH: key 0 falls off the bottom.
        k = '0;
        for (int i = 0; i <= 8; i++) begin
            k[i] = 1'b1;
            apply_stimulus(k);
            check_output($sformatf("fill%0d", i), i, 1, 1, 0, i, (i + 1 > DP) ? DP : i + 1);
        end
        k[0] = 1'b0;
        apply_stimulus(k);
        check_output("rel_discarded", 8, 1, 0, 1, 0, 8);
        k[8] = 1'b0;
        apply_stimulus(k);
        check_output("rel_top", 7, 1, 0, 1, 8, 7);
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus('0);
            check_output($sformatf("drain%0d", i), (i == 7) ? 0 : 7, i != 7, 0, 1, i, 7 - i);
        end

        // Held keys across reset come back as fresh presses, lowest first.
        apply_stimulus(24'h000050);
        check_output("hold4", 4, 1, 1, 0, 4, 1);
        apply_stimulus(24'h000050);
        check_output("hold6", 6, 1, 1, 0, 6, 2);
        rst = 1'b1;
        apply_stimulus(24'h000050);
        check_output("mid_reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        apply_stimulus(24'h000050);
        check_output("repress4", 4, 1, 1, 0, 4, 1);
        apply_stimulus(24'h000050);
        check_output("repress6", 6, 1, 1, 0, 6, 2);
        apply_stimulus('0);
        check_output("clr4", 6, 1, 0, 1, 4, 1);
        apply_stimulus('0);
        check_output("clr6", 0, 0, 0, 1, 6, 0);

        // Key 2 lets go while still queued behind key 1, so it never produces an event.
        apply_stimulus(24'h000006);
        check_output("queue1", 1, 1, 1, 0, 1, 1);
        apply_stimulus(24'h000002);
        check_output("vanish2", 1, 1, 0, 0, 1, 1);
        apply_stimulus(24'h000002);
        check_output("idle", 1, 1, 0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
